// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg
//   Shared types and constants for the SSD1306 procedure scheduler and the
//   microcode ROM image.
//   - e_proc       : procedure identifier (also the active_proc_out encoding)
//   - e_sched_state: scheduler FSM states
//   - DEFAULT_*    : default procedure entry offsets / ROM depth / refresh period
//   - REQ_*        : bit positions of the request pending vector
//   - pick_proc    : fixed-priority pick (shutdown > clear > refresh)
//   - proc_mask    : one-hot pending bit belonging to a procedure
package ssd1306_pkg;

  typedef enum logic [1:0] {
    PROC_INIT     = 2'b00,
    PROC_CLEAR    = 2'b01,
    PROC_REFRESH  = 2'b10,
    PROC_SHUTDOWN = 2'b11
  } e_proc;

  typedef enum logic [2:0] {
    S_RESET,
    S_DISPATCH,
    S_RUN,
    S_IDLE,
    S_OFF
  } e_sched_state;

  // Entry points must match the layout of the microcode ROM image.
  localparam int DEFAULT_MICROCODE_SIZE  = 48;
  localparam int DEFAULT_INIT_OFFSET     = 0;
  localparam int DEFAULT_CLEAR_OFFSET    = 20;
  localparam int DEFAULT_REFRESH_OFFSET  = 32;
  localparam int DEFAULT_SHUTDOWN_OFFSET = 40;
  localparam int DEFAULT_REFRESH_PERIOD  = 1000000;
  localparam int REFRESH_TIMER_BITS      = 24;

  // Pending vector layout (init is never requested, it runs after reset).
  localparam int REQ_CLEAR    = 0;
  localparam int REQ_REFRESH  = 1;
  localparam int REQ_SHUTDOWN = 2;
  localparam int NUM_REQ      = 3;

  // Highest-priority pending request. Caller guarantees pend != 0;
  // PROC_INIT is only returned for an empty vector.
  function automatic e_proc pick_proc(input logic [NUM_REQ-1:0] pend);
    if (pend[REQ_SHUTDOWN]) begin
      return PROC_SHUTDOWN;
    end else if (pend[REQ_CLEAR]) begin
      return PROC_CLEAR;
    end else if (pend[REQ_REFRESH]) begin
      return PROC_REFRESH;
    end else begin
      return PROC_INIT;
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] proc_mask(input e_proc p);
    case (p)
      PROC_CLEAR:    return 3'b001;
      PROC_REFRESH:  return 3'b010;
      PROC_SHUTDOWN: return 3'b100;
      default:       return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_refresh_timer.sv
// ssd1306_refresh_timer
//   Free-running down-counter producing one terminal-count pulse every PERIOD
//   enabled cycles. Holds its value while count_en is low.
//   Ports:
//     clk_in    : system clock
//     reset_in  : synchronous active-high reset (reloads PERIOD-1)
//     count_en  : count enable
//     tick      : high for the enabled cycle in which the counter is at zero
module ssd1306_refresh_timer
  import ssd1306_pkg::*;
#(
  parameter int PERIOD = DEFAULT_REFRESH_PERIOD,
  parameter int WIDTH  = REFRESH_TIMER_BITS
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic count_en,
  output logic tick
);

  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] count_reg;

  // Pulse on the cycle the counter sits at zero; the reload happens on the
  // same edge, so the period is exactly PERIOD enabled cycles.
  assign tick = count_en && (count_reg == '0);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count_reg <= RELOAD;
    end else if (count_en) begin
      if (count_reg == '0) begin
        count_reg <= RELOAD;
      end else begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd1306_procedure_scheduler.sv
// ssd1306_procedure_scheduler
//   Chooses which SSD1306 microcode procedure runs next and drives the
//   start/offset handshake of the microcode executor. Init runs once after
//   reset; afterwards shutdown, clear and refresh requests are arbitrated with
//   fixed priority. A periodic timer adds refresh requests.
//   Ports:
//     clk_in, reset_in       : clock, synchronous active-high reset
//     enable_in              : allows dispatch of requested procedures
//     clear_req_in           : pulse, request screen clear
//     refresh_req_in         : pulse, request display refresh
//     shutdown_req_in        : pulse, request power-down
//     procedure_offset_out   : entry offset presented to the executor
//     procedure_start_out    : start request, held until executor accepts
//     procedure_done_in      : executor idle indicator (low while executing)
//     busy_out               : a procedure is dispatched or running
//     initialized_out        : init procedure has completed
//     off_out                : shutdown procedure has completed
//     active_proc_out        : procedure being run (valid while busy_out)
//     overrun_out            : sticky, timer fired with a refresh still pending
module ssd1306_procedure_scheduler
  import ssd1306_pkg::*;
#(
  parameter int MICROCODE_SIZE  = DEFAULT_MICROCODE_SIZE,
  parameter int INIT_OFFSET     = DEFAULT_INIT_OFFSET,
  parameter int CLEAR_OFFSET    = DEFAULT_CLEAR_OFFSET,
  parameter int REFRESH_OFFSET  = DEFAULT_REFRESH_OFFSET,
  parameter int SHUTDOWN_OFFSET = DEFAULT_SHUTDOWN_OFFSET,
  parameter int REFRESH_PERIOD  = DEFAULT_REFRESH_PERIOD,
  localparam int ADDR_BITS      = $clog2(MICROCODE_SIZE)
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 enable_in,
  input  logic                 clear_req_in,
  input  logic                 refresh_req_in,
  input  logic                 shutdown_req_in,
  output logic [ADDR_BITS-1:0] procedure_offset_out,
  output logic                 procedure_start_out,
  input  logic                 procedure_done_in,
  output logic                 busy_out,
  output logic                 initialized_out,
  output logic                 off_out,
  output logic [1:0]           active_proc_out,
  output logic                 overrun_out
);

  function automatic logic [ADDR_BITS-1:0] offset_of(input e_proc p);
    case (p)
      PROC_CLEAR:    return ADDR_BITS'(CLEAR_OFFSET);
      PROC_REFRESH:  return ADDR_BITS'(REFRESH_OFFSET);
      PROC_SHUTDOWN: return ADDR_BITS'(SHUTDOWN_OFFSET);
      default:       return ADDR_BITS'(INIT_OFFSET);
    endcase
  endfunction

  e_sched_state         state_reg;
  e_proc                active_reg;
  logic [ADDR_BITS-1:0] offset_reg;
  logic                 initialized_reg;
  logic                 off_reg;
  logic                 overrun_reg;
  logic [NUM_REQ-1:0]   pending_reg;

  logic                 refresh_tick;
  logic                 dispatch_ok;
  e_proc                pick;
  logic [NUM_REQ-1:0]   req_set;
  logic [NUM_REQ-1:0]   req_consume;

  // Timer only runs between init completion and shutdown completion.
  ssd1306_refresh_timer #(
    .PERIOD (REFRESH_PERIOD),
    .WIDTH  (REFRESH_TIMER_BITS)
  ) u_refresh_timer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .count_en (initialized_reg && !off_reg),
    .tick     (refresh_tick)
  );

  assign pick        = pick_proc(pending_reg);
  assign dispatch_ok = (state_reg == S_IDLE) && enable_in && initialized_reg
                       && (|pending_reg);

  always_comb begin
    req_set     = '0;
    req_consume = '0;
    if (state_reg != S_OFF) begin
      req_set[REQ_CLEAR]    = clear_req_in;
      req_set[REQ_REFRESH]  = refresh_req_in || refresh_tick;
      req_set[REQ_SHUTDOWN] = shutdown_req_in;
    end
    if (dispatch_ok) begin
      req_consume = proc_mask(pick);
    end
  end

  // One flop per request; a new request in the consuming cycle survives.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pending
    always_ff @(posedge clk_in) begin
      if (reset_in) begin
        pending_reg[gi] <= 1'b0;
      end else begin
        pending_reg[gi] <= (pending_reg[gi] && !req_consume[gi]) || req_set[gi];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_reg       <= S_RESET;
      active_reg      <= PROC_INIT;
      offset_reg      <= ADDR_BITS'(INIT_OFFSET);
      initialized_reg <= 1'b0;
      off_reg         <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      // Refresh already waiting when the timer fires again: one was lost.
      if (refresh_tick && pending_reg[REQ_REFRESH]) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        S_RESET: begin
          // Init bypasses enable_in and the pending vector.
          state_reg  <= S_DISPATCH;
          active_reg <= PROC_INIT;
          offset_reg <= ADDR_BITS'(INIT_OFFSET);
        end
        S_DISPATCH: begin
          // Executor signals accept by leaving its idle state.
          if (!procedure_done_in) begin
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          if (procedure_done_in) begin
            if (active_reg == PROC_SHUTDOWN) begin
              off_reg   <= 1'b1;
              state_reg <= S_OFF;
            end else begin
              state_reg <= S_IDLE;
              if (active_reg == PROC_INIT) begin
                initialized_reg <= 1'b1;
              end
            end
          end
        end
        S_IDLE: begin
          if (dispatch_ok) begin
            state_reg  <= S_DISPATCH;
            active_reg <= pick;
            offset_reg <= offset_of(pick);
          end
        end
        S_OFF: begin
          state_reg <= S_OFF;
        end
        default: begin
          state_reg <= S_RESET;
        end
      endcase
    end
  end

  assign procedure_offset_out = offset_reg;
  assign procedure_start_out  = (state_reg == S_DISPATCH);
  assign busy_out             = (state_reg == S_DISPATCH) || (state_reg == S_RUN);
  assign initialized_out      = initialized_reg;
  assign off_out              = off_reg;
  assign active_proc_out      = active_reg;
  assign overrun_out          = overrun_reg;

endmodule

// File: tb/tb_ssd1306_procedure_scheduler.sv
module tb_ssd1306_procedure_scheduler;

  localparam int P  = 50;
  localparam int AB = 6;

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          enable_in = 1'b1;
  logic          clear_req_in = 1'b0;
  logic          refresh_req_in = 1'b0;
  logic          shutdown_req_in = 1'b0;
  logic          procedure_done_in = 1'b1;
  logic [AB-1:0] procedure_offset_out;
  logic          procedure_start_out;
  logic          busy_out;
  logic          initialized_out;
  logic          off_out;
  logic [1:0]    active_proc_out;
  logic          overrun_out;

  always #5 clk_in = ~clk_in;

  ssd1306_procedure_scheduler #(
    .MICROCODE_SIZE  (48),
    .INIT_OFFSET     (0),
    .CLEAR_OFFSET    (20),
    .REFRESH_OFFSET  (32),
    .SHUTDOWN_OFFSET (40),
    .REFRESH_PERIOD  (P)
  ) dut (
    .clk_in               (clk_in),
    .reset_in             (reset_in),
    .enable_in            (enable_in),
    .clear_req_in         (clear_req_in),
    .refresh_req_in       (refresh_req_in),
    .shutdown_req_in      (shutdown_req_in),
    .procedure_offset_out (procedure_offset_out),
    .procedure_start_out  (procedure_start_out),
    .procedure_done_in    (procedure_done_in),
    .busy_out             (busy_out),
    .initialized_out      (initialized_out),
    .off_out              (off_out),
    .active_proc_out      (active_proc_out),
    .overrun_out          (overrun_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: procedure codes 0 init, 1 clear, 2 refresh, 3 shutdown.
  bit       m_valid = 0;
  bit       m_boot, m_inflight, m_accepted, m_off, m_init_done, m_overrun;
  bit [3:0] m_pend;
  int       m_proc;
  int       m_tcnt;   // enabled cycles elapsed since last timer expiry
  int       prio[3] = '{3, 1, 2};

  // Executor model
  int ex_accept_delay = 3;
  int ex_run_len = 10;
  int ex_wait = 3;
  int ex_cnt = 0;
  bit ex_running = 0;

  function automatic int offset_of(input int p);
    case (p)
      1:       return 20;
      2:       return 32;
      3:       return 40;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit       tick;
    bit       was_counting;
    bit [3:0] setv;
    bit [3:0] cons;
    if (reset_in) begin
      m_valid = 1; m_boot = 1; m_inflight = 0; m_accepted = 0; m_off = 0;
      m_init_done = 0; m_overrun = 0; m_pend = 0; m_proc = 0; m_tcnt = 0;
      return;
    end
    was_counting = m_init_done && !m_off;
    tick = was_counting && (m_tcnt == P - 1);
    if (tick && m_pend[2]) m_overrun = 1;
    setv = 0;
    cons = 0;
    if (!m_off) begin
      setv[1] = clear_req_in;
      setv[2] = refresh_req_in || tick;
      setv[3] = shutdown_req_in;
    end
    if (m_boot) begin
      m_boot = 0; m_inflight = 1; m_accepted = 0; m_proc = 0;
    end else if (m_inflight && !m_accepted) begin
      if (!procedure_done_in) m_accepted = 1;
    end else if (m_inflight) begin
      if (procedure_done_in) begin
        m_inflight = 0;
        if (m_proc == 3) m_off = 1;
        if (m_proc == 0) m_init_done = 1;
      end
    end else if (!m_off && enable_in && m_init_done) begin
      for (int k = 0; k < 3; k++) begin
        if (m_pend[prio[k]] && !m_inflight) begin
          m_inflight = 1; m_accepted = 0; m_proc = prio[k]; cons[prio[k]] = 1;
        end
      end
    end
    m_pend = (m_pend & ~cons) | setv;
    if (was_counting) m_tcnt = (m_tcnt == P - 1) ? 0 : m_tcnt + 1;
  endtask

  task automatic compare();
    if (!m_valid) return;
    check("start", procedure_start_out, int'(m_inflight && !m_accepted));
    check("busy", busy_out, int'(m_inflight));
    check("offset", procedure_offset_out, offset_of(m_proc));
    check("active", active_proc_out, m_proc);
    check("initialized", initialized_out, int'(m_init_done));
    check("off", off_out, int'(m_off));
    check("overrun", overrun_out, int'(m_overrun));
  endtask

  task automatic exec_drive();
    if (reset_in) begin
      ex_running = 0; procedure_done_in = 1; ex_wait = ex_accept_delay;
    end else if (ex_running) begin
      if (ex_cnt <= 1) begin
        procedure_done_in = 1; ex_running = 0; ex_wait = ex_accept_delay;
      end else begin
        ex_cnt--;
      end
    end else if (procedure_start_out) begin
      if (ex_wait <= 0) begin
        procedure_done_in = 0; ex_running = 1; ex_cnt = ex_run_len;
      end else begin
        ex_wait--;
      end
    end else begin
      ex_wait = ex_accept_delay;
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
    model_step();
    compare();
    exec_drive();
    clear_req_in = 0;
    refresh_req_in = 0;
    shutdown_req_in = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_offset"}, procedure_offset_out, 0);
    check({tag, "_start"}, procedure_start_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_init"}, initialized_out, 0);
    check({tag, "_off"}, off_out, 0);
    check({tag, "_active"}, active_proc_out, 0);
    check({tag, "_overrun"}, overrun_out, 0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy_out; i++) cycle();
    check("wait_idle", busy_out, 0);
  endtask

  task automatic wait_init(input int budget);
    for (int i = 0; i < budget && !initialized_out; i++) cycle();
    check("init_done", initialized_out, 1);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and init dispatch
    reset_in = 1;
    cycle();
    cycle();
    check_reset_values("rst");
    reset_in = 0;
    cycle();
    check("init_start", procedure_start_out, 1);
    check("init_offset", procedure_offset_out, 0);
    check("init_busy", busy_out, 1);
    wait_init(100);
    check("init_idle", busy_out, 0);

    // Clear and refresh in the same cycle: clear first, then refresh
    clear_req_in = 1;
    refresh_req_in = 1;
    cycle();
    cycle();
    check("clr_start", procedure_start_out, 1);
    check("clr_offset", procedure_offset_out, 20);
    check("clr_active", active_proc_out, 1);
    wait_idle(200);
    cycle();
    check("ref_start", procedure_start_out, 1);
    check("ref_offset", procedure_offset_out, 32);
    check("ref_active", active_proc_out, 2);

    // Refresh requested while a refresh runs -> one more refresh
    for (int i = 0; i < 50 && procedure_start_out; i++) cycle();
    refresh_req_in = 1;
    cycle();
    wait_idle(200);
    cycle();
    check("ref2_start", procedure_start_out, 1);
    check("ref2_offset", procedure_offset_out, 32);

    // enable_in low holds a pending clear
    enable_in = 0;
    wait_idle(200);
    clear_req_in = 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("en_hold_start", procedure_start_out, 0);
    end
    enable_in = 1;
    cycle();
    check("en_start", procedure_start_out, 1);
    check("en_offset", procedure_offset_out, 20);

    // Reset while a procedure runs
    for (int i = 0; i < 50 && !(busy_out && !procedure_start_out); i++) cycle();
    check("run_reached", procedure_start_out, 0);
    reset_in = 1;
    cycle();
    check_reset_values("midrun");
    reset_in = 0;
    cycle();
    check("reinit_start", procedure_start_out, 1);
    check("reinit_offset", procedure_offset_out, 0);
    wait_init(100);

    // Long executor stall while refresh pending -> overrun
    ex_accept_delay = 120;
    refresh_req_in = 1;
    cycle();
    for (int i = 0; i < 140; i++) cycle();
    check("overrun", overrun_out, 1);
    ex_accept_delay = 3;
    wait_idle(400);

    // Shutdown beats a pending clear; afterwards everything is ignored
    enable_in = 0;
    wait_idle(400);
    clear_req_in = 1;
    cycle();
    shutdown_req_in = 1;
    cycle();
    enable_in = 1;
    cycle();
    check("shut_start", procedure_start_out, 1);
    check("shut_offset", procedure_offset_out, 40);
    check("shut_active", active_proc_out, 3);
    for (int i = 0; i < 100 && !off_out; i++) cycle();
    check("off", off_out, 1);
    for (int i = 0; i < 60; i++) begin
      clear_req_in = ($urandom_range(0, 3) == 0);
      refresh_req_in = ($urandom_range(0, 3) == 0);
      cycle();
    end
    check("off_no_start", procedure_start_out, 0);
    check("off_no_busy", busy_out, 0);

    // Randomized traffic
    reset_in = 1;
    cycle();
    reset_in = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) enable_in = !enable_in;
      clear_req_in = ($urandom_range(0, 19) == 0);
      refresh_req_in = ($urandom_range(0, 24) == 0);
      shutdown_req_in = ($urandom_range(0, 399) == 0);
      ex_accept_delay = $urandom_range(0, 6);
      ex_run_len = $urandom_range(1, 12);
      reset_in = ($urandom_range(0, 599) == 0) || (off_out && ($urandom_range(0, 39) == 0));
      cycle();
    end
    reset_in = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ssd1306_procedure_scheduler.md
Name: ssd1306_procedure_scheduler

Overview:
Sequences the SSD1306 microcode executor by choosing which microcode procedure runs next and issuing its start/offset handshake.
- Runs the init procedure automatically after reset.
- Then arbitrates between shutdown, clear and refresh requests, with fixed priority.
- Generates a periodic refresh request from an internal timer.
- Sits between the frequency-counter application logic and the microcode executor.

Parameters:
MICROCODE_SIZE, 48, microcode ROM depth; ADDR_BITS = $clog2(MICROCODE_SIZE) (localparam)
INIT_OFFSET, 0, entry address of power-up/init procedure
CLEAR_OFFSET, 20, entry address of screen-clear procedure
REFRESH_OFFSET, 32, entry address of display-update procedure
SHUTDOWN_OFFSET, 40, entry address of power-down procedure
REFRESH_PERIOD, 1000000, clk_in cycles between automatic refresh requests (>=2)

Ports:
clk_in  input  1  system clock
reset_in  input  1  synchronous, active-high reset
enable_in  input  1  1 -> dispatch allowed; 0 -> requests held pending, no new dispatch
clear_req_in  input  1  one-cycle pulse requesting clear
refresh_req_in  input  1  one-cycle pulse requesting refresh (OR-ed with timer)
shutdown_req_in  input  1  one-cycle pulse requesting power-down
procedure_offset_out  output  ADDR_BITS  offset presented to executor
procedure_start_out  output  1  start request to executor
procedure_done_in  input  1  executor idle indicator
busy_out  output  1  1 while any procedure is in flight
initialized_out  output  1  1 after init procedure has completed
off_out  output  1  1 after shutdown procedure has completed
active_proc_out  output  2  00 init, 01 clear, 10 refresh, 11 shutdown; valid while busy_out
overrun_out  output  1  sticky: timer fired while refresh still pending

Behaviour:
- Reset values: offset_out=INIT_OFFSET, start_out=0, busy_out=0, initialized_out=0, off_out=0, active_proc_out=00, overrun_out=0. Pending bits and timer cleared; state S_RESET.
- Reset mid-procedure aborts tracking immediately. Init is re-run afterwards; the executor is reset by its own reset_in.
- States and transitions:
  - S_RESET -> S_DISPATCH with init selected (one cycle).
  - S_DISPATCH: start_out=1 (combinational from state); offset_out already registered and stable.
  - S_DISPATCH -> S_RUN on the first cycle procedure_done_in==0. start_out drops in S_RUN.
  - S_RUN -> S_IDLE when procedure_done_in==1.
    - If the procedure was init: set initialized_out.
    - If it was shutdown: set off_out and go to S_OFF instead.
  - S_IDLE: if enable_in && initialized_out && any pending bit -> pick the highest-priority pending request (shutdown > clear > refresh), clear its pending bit, load offset_out and active_proc_out, go to S_DISPATCH. Minimum idle-to-dispatch turnaround is 1 cycle.
  - S_OFF is terminal until reset_in. All requests are ignored there, and the timer is stopped.
- Init dispatch ignores enable_in.
- busy_out = state in {S_DISPATCH, S_RUN}.
- Pending bits are set by request pulses at any time except S_OFF, including during execution of the same procedure type. A request arriving in the same cycle its bit is consumed remains pending (set wins).
- Refresh timer:
  - 24-bit down-counter loaded with REFRESH_PERIOD-1.
  - Counts only while initialized_out && !off_out.
  - At zero: reload and set refresh pending. If refresh was already pending in that cycle, set overrun_out (cleared only by reset).
- Executor-accept latency is unbounded (it waits for spi ready); start_out is held until accept.

Decomposition:
- Package ssd1306_pkg:
  - e_proc enum (PROC_INIT, PROC_CLEAR, PROC_REFRESH, PROC_SHUTDOWN), 2-bit.
  - Default procedure offset localparams, shared with the microcode ROM image.
- Sub-module ssd1306_refresh_timer: counter with enable, terminal-count pulse and reload.
- Priority select stays inline.

Test Plan:
- Release reset, executor model drops done 3 cycles after start and raises it 10 cycles later -> start_out asserted with offset 0; initialized_out=1 one cycle after done returns; busy_out high exactly during the handshake.
- clear_req and refresh_req pulsed in the same cycle while idle -> clear (offset 20) dispatched first, then refresh (offset 32); active_proc_out 01 then 10.
- refresh_req pulsed during a running refresh -> exactly one more refresh dispatched after completion.
- REFRESH_PERIOD=50, executor stalls accept for 120 cycles -> overrun_out=1; only one refresh pending.
- shutdown_req with clear pending -> shutdown (offset 40) dispatched; off_out=1; later requests ignored; timer frozen.
- enable_in=0 with clear pending -> no start_out; raising enable_in -> dispatch 1 cycle later. reset_in during S_RUN -> all outputs at reset values next cycle, then init re-dispatched.
